seg7_scan_mux: RTL and testbench
================================

Name: seg7_scan_mux

Overview:
- Downstream display stage for the divider front-end. Takes the four registered active-low 7-segment patterns: quotient ones/tens and remainder ones/tens.
- Time-multiplexes them onto one shared segment bus with one-hot active-low digit enables, as the board's common-anode display requires.
- Adds these features:
  - per-slot anti-ghosting blank time
  - frame-coherent input snapshot (no tearing)
  - per-digit zero suppression
  - whole-display blink (used for divide-by-zero indication)

Parameters:
- DIGITS, 4, number of multiplexed digits (>=2).
- REFRESH_DIV, 50000, clk cycles per digit slot (>= BLANK_CYC+1).
- BLANK_CYC, 16, cycles at the start of each slot with all digits off (>=1).
- BLINK_FRAMES, 64, frames per blink half-period (>=1).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- en  in  1  display enable
- blink  in  1  blink request
- lzb_mask  in  DIGITS  per-digit zero-suppress enable
- seg_in  in  7*DIGITS  active-low patterns; digit i at [7i+6:7i]; digit 0 is the rightmost
- seg_out  out  7  active-low segments {g..a}
- an  out  DIGITS  active-low digit enables, at most one low
- frame_tick  out  1  one-cycle pulse when a new snapshot is loaded

Behaviour:
- One clock is used. Reset is asynchronous and active-low.
- Reset values: an = all 1, seg_out = 7'h7F, frame_tick = 0, snapshot = all 1, cnt = 0, slot = 0, frame counter = 0, blink phase = 0.
- Prescaler cnt:
  - counts 0..REFRESH_DIV-1 while en=1
  - at REFRESH_DIV-1 wraps to 0 and increments slot modulo DIGITS
- Snapshot:
  - condition L = en & (cnt==0) & (slot==0)
  - on that edge, snapshot <= seg_in and frame_tick <= 1
  - frame_tick is 0 in every other cycle
  - seg_in changes outside L never reach the display in the current frame
- Output registers an and seg_out are computed from the current cnt/slot/snapshot/phase, so there is one cycle of latency.
- Output value for each slot:
  - Blank (an = all 1, seg_out = 7'h7F) if any of these holds:
    - en=0
    - cnt < BLANK_CYC
    - blink phase = 1
    - lzb_mask[slot]=1 and snapshot[slot] == 7'b1000000 (the zero glyph)
  - Otherwise an = ~(1<<slot) and seg_out = snapshot[slot].
- Frame period = DIGITS*REFRESH_DIV cycles.
- Blink:
  - the frame counter increments on each L, 0..BLINK_FRAMES-1
  - at wrap, phase toggles
  - while blink=0, the frame counter and phase are held at 0, so asserting blink always starts with a lit half-period
  - deasserting blink clears phase in the next cycle; the display is lit from the next non-blank cycle
- en=0:
  - cnt, slot, frame counter and phase are forced to 0
  - snapshot is held
  - outputs are blank from the next cycle
  - re-enable starts at slot 0 with L in the first enabled cycle
- Reset mid-frame is asynchronous: all state returns to reset values immediately.
- Simultaneous events:
  - L and blink-phase toggle on the same edge are allowed and independent
  - en falling on the edge where L would occur: en wins, no load, no tick
- Invariant: an never has more than one bit low, and is never low during the blank window.

Decomposition:
- Shared package seg7_pkg holds:
  - localparam SEG_BLANK = 7'h7F
  - localparam SEG_ZERO = 7'b1000000
  - typedef seg_t = logic [6:0]
- Both scan and this block use the package.
- One natural sub-module: seg7_refresh_timer (prescaler + slot counter + L strobe), reusable by other display stages.
- Blink and zero-suppress logic stay in the top-level.

Test Plan:
Common configuration: DIGITS=4, REFRESH_DIV=8, BLANK_CYC=2, BLINK_FRAMES=2.
1. Reset:
   - Stimulus: hold rst=0 for 5 cycles with en=1; release.
   - Required: an=4'hF and seg_out=7'h7F during reset and for the first 3 cycles after release; frame_tick pulses in the first cycle after release.
2. Basic scan:
   - Stimulus: seg_in digits 0..3 = 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001; lzb_mask=0.
   - Required: an steps 1110, 1101, 1011, 0111; each digit lit 6 cycles then dark 2 cycles with the matching seg_out; frame_tick every 32 cycles.
3. Tearing:
   - Stimulus: change digit 0 to 7'b0010010 during slot 2.
   - Required: slot 0 of the current frame is unchanged; the new pattern appears only in slot 0 after the next frame_tick.
4. Zero suppression:
   - Stimulus: lzb_mask=4'b1000 with digit3=7'b1000000.
   - Required: an[3] never goes low and digits 0-2 are lit normally. With digit3=7'b1111001, slot 3 lights.
5. Blink:
   - Stimulus: assert blink.
   - Required: 2 frames lit, then 2 frames fully dark (an=4'hF), repeating. Deassert blink during a dark frame: lit again from the next non-blank cycle.
6. Enable / reset mid-operation:
   - Stimulus: drop en in slot 1 at cnt=4; raise it 10 cycles later.
   - Required: outputs go blank the next cycle; on re-enable, frame_tick pulses immediately and the scan restarts at slot 0. Asserting rst mid-slot blanks the outputs asynchronously.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions for the display stages.
// Segment patterns are active-low, bit order {g,f,e,d,c,b,a}.
package seg7_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'h7F;      // all segments off
    localparam seg_t SEG_ZERO  = 7'b1000000; // glyph "0"

    // True when a pattern is the zero glyph, used for zero suppression.
    function automatic logic is_zero_glyph(input seg_t pattern);
        return pattern == SEG_ZERO;
    endfunction

endpackage

// File: rtl/seg7_refresh_timer.sv
// Refresh timebase for multiplexed displays: a prescaler that splits time
// into digit slots, a slot counter, and a strobe marking the first cycle of
// every frame (cnt==0 in slot 0). Disabling the timer parks it at frame start,
// so re-enabling always begins a fresh frame.
module seg7_refresh_timer #(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    output logic [$clog2(REFRESH_DIV)-1:0] cnt,
    output logic [$clog2(DIGITS)-1:0]      slot,
    output logic                          load
);

    localparam int CNT_W  = $clog2(REFRESH_DIV);
    localparam int SLOT_W = $clog2(DIGITS);

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(DIGITS - 1);

    // Prescaler and slot counter; both held at zero while disabled.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt  <= '0;
            slot <= '0;
        end else if (!en) begin
            cnt  <= '0;
            slot <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt  <= '0;
            slot <= (slot == SLOT_LAST) ? '0 : slot + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Frame-start strobe: first cycle of slot 0 while running.
    assign load = en && (cnt == '0) && (slot == '0);

endmodule

// File: rtl/seg7_scan_mux.sv
// Time-multiplexed driver for a common-anode 7-segment display.
// Captures all digit patterns once per frame so a digit never tears mid-scan,
// blanks each slot briefly to avoid ghosting, optionally hides zero digits,
// and can blink the whole display. Outputs are registered (one cycle latency).
module seg7_scan_mux
    import seg7_pkg::*;
#(
    parameter int DIGITS       = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYC    = 16,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  blink,
    input  logic [DIGITS-1:0]     lzb_mask,
    input  logic [7*DIGITS-1:0]   seg_in,
    output logic [6:0]            seg_out,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_tick
);

    localparam int CNT_W  = $clog2(REFRESH_DIV);
    localparam int SLOT_W = $clog2(DIGITS);
    localparam int FR_W   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [CNT_W-1:0] BLANK_LIM = CNT_W'(BLANK_CYC);
    localparam logic [FR_W-1:0]  FR_LAST   = FR_W'(BLINK_FRAMES - 1);

    logic [CNT_W-1:0]    cnt;
    logic [SLOT_W-1:0]   slot;
    logic                load;

    logic [7*DIGITS-1:0] snap;
    logic [FR_W-1:0]     frame_cnt;
    logic                phase;

    seg_t                cur_seg;
    logic                dark;
    logic [DIGITS-1:0]   an_next;
    seg_t                seg_next;

    seg7_refresh_timer #(
        .DIGITS      (DIGITS),
        .REFRESH_DIV (REFRESH_DIV)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .cnt  (cnt),
        .slot (slot),
        .load (load)
    );

    // Frame snapshot of all digit patterns plus the frame-start pulse.
    // NOTE: the snapshot is reset (to all segments off) because the display
    // reads it directly; an unreset pattern store would show garbage glyphs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            snap       <= '1;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= load;
            if (load) begin
                snap <= seg_in;
            end
        end
    end

    // Blink timebase: counts frames while blinking, toggling phase each
    // BLINK_FRAMES frames; parked at the lit half whenever blink or en is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_cnt <= '0;
            phase     <= 1'b0;
        end else if (!en || !blink) begin
            frame_cnt <= '0;
            phase     <= 1'b0;
        end else if (load) begin
            if (frame_cnt == FR_LAST) begin
                frame_cnt <= '0;
                phase     <= ~phase;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    // Next digit enable / segment value for the current slot.
    // NOTE: every output gets a default before the conditional update, so no
    // path leaves a value unassigned and no latch is inferred.
    always_comb begin
        an_next  = '1;
        seg_next = SEG_BLANK;
        cur_seg  = snap[7*int'(slot) +: 7];
        dark     = !en
                || (cnt < BLANK_LIM)
                || phase
                || (lzb_mask[slot] && is_zero_glyph(cur_seg));
        if (!dark) begin
            an_next[slot] = 1'b0;
            seg_next      = cur_seg;
        end
    end

    // Registered display outputs; reset drives the display dark immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            an      <= '1;
            seg_out <= SEG_BLANK;
        end else begin
            an      <= an_next;
            seg_out <= seg_next;
        end
    end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Scoreboard bench for seg7_scan_mux. A reference model, written in terms of
// elapsed enabled time and frame counts, predicts each registered output
// vector at the clock edge; a monitor compares on the falling edge.
module tb_seg7_scan_mux;

    localparam int DIGITS = 4;
    localparam int RD     = 8;
    localparam int BC     = 2;
    localparam int BF     = 2;
    localparam int FRAME  = DIGITS * RD;

    localparam logic [6:0] ZERO  = 7'b1000000;
    localparam logic [6:0] BLANK = 7'h7F;

    logic              clk      = 1'b0;
    logic              rst      = 1'b0;
    logic              en       = 1'b1;
    logic              blink    = 1'b0;
    logic [DIGITS-1:0] lzb_mask = '0;
    logic [27:0]       seg_in   = '1;
    logic [6:0]        seg_out;
    logic [DIGITS-1:0] an;
    logic              frame_tick;

    seg7_scan_mux #(
        .DIGITS       (DIGITS),
        .REFRESH_DIV  (RD),
        .BLANK_CYC    (BC),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .blink      (blink),
        .lzb_mask   (lzb_mask),
        .seg_in     (seg_in),
        .seg_out    (seg_out),
        .an         (an),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       tick;
    } exp_t;

    exp_t sb_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Reference model state: enabled time within the frame, frames seen while
    // blinking, and the frame's captured patterns.
    int         m_t = 0;
    int         m_l = 0;
    logic [6:0] m_snap [DIGITS];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
        end
    endtask

    // Model: predict the output vector registered at this edge, then advance.
    always @(posedge clk) begin
        exp_t e;
        int   cnt, slot;
        bit   ph, l, dark;
        if (!rst) begin
            m_t = 0;
            m_l = 0;
            for (int i = 0; i < DIGITS; i++) m_snap[i] = BLANK;
            e = '{an: 4'hF, seg: BLANK, tick: 1'b0};
        end else begin
            cnt  = m_t % RD;
            slot = m_t / RD;
            ph   = ((m_l / BF) % 2) == 1;
            l    = en && (m_t == 0);
            dark = !en || (cnt < BC) || ph || (lzb_mask[slot] && m_snap[slot] == ZERO);
            e.an   = dark ? 4'hF : ~(4'b0001 << slot);
            e.seg  = dark ? BLANK : m_snap[slot];
            e.tick = l;
            if (l) begin
                for (int i = 0; i < DIGITS; i++) m_snap[i] = seg_in[7*i +: 7];
            end
            if (!en || !blink) m_l = 0;
            else if (l)        m_l = (m_l + 1) % (2 * BF);
            m_t = en ? (m_t + 1) % FRAME : 0;
        end
        sb_q.push_back(e);
    end

    // Monitor: compare DUT outputs with the oldest prediction.
    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL scoreboard_empty at %0t: no prediction queued, expected one", $time);
        end else begin
            e = sb_q.pop_front();
            check("an", 32'(an), 32'(e.an));
            check("seg_out", 32'(seg_out), 32'(e.seg));
            check("frame_tick", 32'(frame_tick), 32'(e.tick));
        end
    end

    task automatic wait_model_t(input int target);
        int budget = 4 * FRAME;
        while (m_t != target && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check("sync_timeout", 32'(m_t), 32'(target));
    endtask

    initial begin
        // Reset held with en=1, then release.
        seg_in = {7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};
        repeat (5) @(negedge clk);
        check("reset_an", 32'(an), 32'hF);
        check("reset_seg", 32'(seg_out), 32'(BLANK));
        rst = 1'b1;

        // Basic scan over two frames.
        repeat (2 * FRAME) @(negedge clk);

        // Tearing: change digit 0 during slot 2.
        wait_model_t(2 * RD + 3);
        seg_in[6:0] = 7'b0010010;
        repeat (2 * FRAME) @(negedge clk);

        // Zero suppression on digit 3, then a non-zero digit 3.
        lzb_mask     = 4'b1000;
        seg_in[27:21] = ZERO;
        repeat (2 * FRAME) @(negedge clk);
        seg_in[27:21] = 7'b1111001;
        repeat (2 * FRAME) @(negedge clk);
        lzb_mask = '0;

        // Blink: run into the dark half, then release mid-dark.
        blink = 1'b1;
        repeat (6 * FRAME + 10) @(negedge clk);
        blink = 1'b0;
        repeat (FRAME) @(negedge clk);

        // Enable drop in slot 1 at cnt=4, re-enable 10 cycles later.
        wait_model_t(RD + 4);
        en = 1'b0;
        repeat (10) @(negedge clk);
        en = 1'b1;
        repeat (2 * FRAME) @(negedge clk);

        // Asynchronous reset in the lit part of a slot.
        wait_model_t(RD + 4);
        check("pre_rst_lit_an", 32'(an), 32'hD);
        #2 rst = 1'b0;
        #1;
        check("async_rst_an", 32'(an), 32'hF);
        check("async_rst_seg", 32'(seg_out), 32'(BLANK));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (FRAME) @(negedge clk);

        // Randomized operation.
        repeat (3000) begin
            @(negedge clk);
            if ($urandom_range(0, 7) == 0) begin
                int d = $urandom_range(0, DIGITS - 1);
                seg_in[7*d +: 7] = ($urandom_range(0, 2) == 0) ? ZERO : 7'($urandom);
            end
            if ($urandom_range(0, 49) == 0) lzb_mask = 4'($urandom);
            if ($urandom_range(0, 149) == 0) blink = ~blink;
            if (en) begin
                if ($urandom_range(0, 59) == 0) en = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
                en = 1'b1;
            end
            if ($urandom_range(0, 999) == 0) begin
                rst = 1'b0;
                @(negedge clk);
                rst = 1'b1;
            end
        end

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
